// File: rtl/iob_native_pkg.sv
// Shared types and constants for the iob-native memory responder.
package iob_native_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } state_e;

    localparam int unsigned CntW = 8;

    function automatic int unsigned strb_w(int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/iob_ram_sp_be.sv
// Single-port RAM with synchronous read and per-byte write enables.
module iob_ram_sp_be
    import iob_native_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                en_i,
    input  logic [DATA_W/8-1:0] we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   din_i,
    output logic [DATA_W-1:0]   dout_o
);

    localparam int unsigned StrbW = strb_w(DATA_W);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] dout_q;

    // The array has no reset so its contents survive a reset.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int b = 0; b < StrbW; b++) begin
                if (we_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= din_i[b*8 +: 8];
                end
            end
        end
    end

    // Output register only updates on reads; writes leave the last read value.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dout_q <= '0;
        end else if (en_i && !(|we_i)) begin
            dout_q <= mem_q[addr_i];
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/iob_native_mem_resp.sv
// iob-native responder: word-addressed memory with byte strobes and fixed
// access latency, one transaction in flight.
module iob_native_mem_resp
    import iob_native_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                req_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                ack_o
);

    localparam int unsigned StrbW = strb_w(DATA_W);

    if (LATENCY < 1 || LATENCY > 255) begin : gen_bad_latency
        $error("iob_native_mem_resp: LATENCY must be in 1..255");
    end
    if (DATA_W % 8 != 0) begin : gen_bad_data_w
        $error("iob_native_mem_resp: DATA_W must be a multiple of 8");
    end

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [StrbW-1:0]  wstrb_q;

    logic              access;
    logic              ram_en;
    logic [StrbW-1:0]  ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && req_i) begin
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                wstrb_q <= wstrb_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        access  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    cnt_d = CntW'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = StAck;
                        access  = 1'b1;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StAck;
                    access  = 1'b1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Direct operands are needed when LATENCY==1 enters ACK from IDLE.
    // Reset suppresses the access so a pending write is dropped.
    always_comb begin
        ram_en   = access && !reset_i;
        ram_addr = (state_q == StIdle) ? addr_i  : addr_q;
        ram_din  = (state_q == StIdle) ? wdata_i : wdata_q;
        ram_we   = '0;
        if (ram_en) begin
            ram_we = (state_q == StIdle) ? wstrb_i : wstrb_q;
        end
    end

    iob_ram_sp_be #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .din_i   (ram_din),
        .dout_o  (rdata_o)
    );

    assign ack_o = (state_q == StAck);

endmodule

// File: tb/tb_iob_native_mem_resp.sv
// Directed bench for iob_native_mem_resp at LATENCY 2, 1 and 5.
module tb_iob_native_mem_resp;

    logic        clk = 1'b0;
    logic        reset;
    logic        req   [3];
    logic [9:0]  addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  wstrb [3];
    logic [31:0] rdata0, rdata1, rdata2;
    logic        ack0, ack1, ack2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    iob_native_mem_resp #(.ADDR_W(10), .DATA_W(32), .LATENCY(2)) u_dut_l2 (
        .clk_i(clk), .reset_i(reset), .req_i(req[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .wstrb_i(wstrb[0]), .rdata_o(rdata0), .ack_o(ack0)
    );
    iob_native_mem_resp #(.ADDR_W(10), .DATA_W(32), .LATENCY(1)) u_dut_l1 (
        .clk_i(clk), .reset_i(reset), .req_i(req[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .wstrb_i(wstrb[1]), .rdata_o(rdata1), .ack_o(ack1)
    );
    iob_native_mem_resp #(.ADDR_W(10), .DATA_W(32), .LATENCY(5)) u_dut_l5 (
        .clk_i(clk), .reset_i(reset), .req_i(req[2]), .addr_i(addr[2]),
        .wdata_i(wdata[2]), .wstrb_i(wstrb[2]), .rdata_o(rdata2), .ack_o(ack2)
    );

    function automatic logic get_ack(int idx);
        case (idx)
            0:       return ack0;
            1:       return ack1;
            default: return ack2;
        endcase
    endfunction

    function automatic logic [31:0] get_rdata(int idx);
        case (idx)
            0:       return rdata0;
            1:       return rdata1;
            default: return rdata2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge. mode 0: drop req in the ack cycle; mode 1: hold req
    // high through ack; mode 2: after accept, move addr/wdata and drop req.
    // lat counts negedges after the accepting edge up to the one that sees ack.
    task automatic xfer(input int idx, input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int mode,
                        output logic [31:0] rd, output int lat);
        req[idx]   = 1'b1;
        addr[idx]  = a;
        wdata[idx] = d;
        wstrb[idx] = s;
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (get_ack(idx)) begin
                lat = k;
                break;
            end
            if (k == 1 && mode == 2) begin
                addr[idx]  = a + 10'd1;
                wdata[idx] = ~d;
                req[idx]   = 1'b0;
            end
        end
        if (lat == 0) check("ack_timeout", 32'd0, 32'd1);
        rd = get_rdata(idx);
        if (mode != 1) req[idx] = 1'b0;
        @(negedge clk);
        check("ack_width", 32'(get_ack(idx)), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        int          exp_lat;
        logic        seen;

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; addr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
        end
        repeat (5) @(negedge clk);
        reset = 1'b0;
        check("rst_ack_l2", 32'(ack0), 32'd0);
        check("rst_ack_l1", 32'(ack1), 32'd0);
        check("rst_ack_l5", 32'(ack2), 32'd0);
        check("rst_rdata_l2", rdata0, 32'd0);
        check("rst_rdata_l1", rdata1, 32'd0);
        check("rst_rdata_l5", rdata2, 32'd0);

        // Full-word writes then reads.
        for (int i = 0; i < 5; i++) begin
            xfer(0, 10'(i), 32'(i * 3), 4'hF, 0, rd, lat);
            check("s1_wr_lat", 32'(lat), 32'd2);
        end
        for (int i = 0; i < 5; i++) begin
            xfer(0, 10'(i), 32'h0, 4'h0, 0, rd, lat);
            check("s1_rd_lat", 32'(lat), 32'd2);
            check("s1_rd_data", rd, 32'(i * 3));
        end

        // Byte strobes.
        xfer(0, 10'd7, 32'hDEADBEEF, 4'hF, 0, rd, lat);
        xfer(0, 10'd7, 32'h11223344, 4'b0101, 0, rd, lat);
        check("s2_wr_keeps_rdata", rd, 32'h0000000C);
        xfer(0, 10'd7, 32'h0, 4'h0, 0, rd, lat);
        check("s2_rd_data", rd, 32'hDE22BE44);

        // Latency sweep with req held high through ack.
        for (int idx = 1; idx <= 2; idx++) begin
            exp_lat = (idx == 1) ? 1 : 5;
            xfer(idx, 10'd0, 32'hA5A50000 + 32'(idx), 4'hF, 0, rd, lat);
            check("s3_wr_lat", 32'(lat), 32'(exp_lat));
            xfer(idx, 10'd0, 32'h0, 4'h0, 1, rd, lat);
            check("s3_rd_lat", 32'(lat), 32'(exp_lat));
            check("s3_rd_data", rd, 32'hA5A50000 + 32'(idx));
            xfer(idx, 10'd0, 32'h0, 4'h0, 1, rd, lat);
            check("s3_b2b_lat", 32'(lat), 32'(exp_lat));
            check("s3_b2b_data", rd, 32'hA5A50000 + 32'(idx));
            req[idx] = 1'b0;
        end

        // Operands move and req drops during WAIT.
        xfer(0, 10'd3, 32'h0, 4'h0, 2, rd, lat);
        check("s4_lat", 32'(lat), 32'd2);
        check("s4_rdata", rd, 32'h9);

        // Reset during WAIT abandons a pending write.
        req[0] = 1'b1; addr[0] = 10'd2; wdata[0] = 32'hCAFEF00D; wstrb[0] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("s5_wait_ack", 32'(ack0), 32'd0);
        reset  = 1'b1;
        req[0] = 1'b0;
        seen   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack0) seen = 1'b1;
        end
        check("s5_rdata_rst", rdata0, 32'd0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack0) seen = 1'b1;
        end
        check("s5_no_ack", 32'(seen), 32'd0);
        xfer(0, 10'd2, 32'h0, 4'h0, 0, rd, lat);
        check("s5_mem_kept", rd, 32'h6);

        // Write then immediate read.
        xfer(0, 10'd9, 32'h12345678, 4'hF, 0, rd, lat);
        check("s6_wr_keeps_rdata", rd, 32'h6);
        xfer(0, 10'd9, 32'h0, 4'h0, 0, rd, lat);
        check("s6_rd_lat", 32'(lat), 32'd2);
        check("s6_rd_data", rd, 32'h12345678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
